// File: rtl/fifo_pkg.sv
// Shared FIFO parameters used as defaults by the FIFO-side blocks.
package fifo_pkg;
  parameter int DATA_WIDTH = 16;
endpackage

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets N_REQ producers share one FIFO write port,
// granting each owner a burst of up to MAX_BURST writes.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_BURST  = 4,
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  localparam int OW = $clog2(N_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wr_data,
  output logic [OW-1:0]               grant_id,
  output logic                        busy
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_next;
  logic [OW-1:0]   owner, owner_next;
  logic [OW-1:0]   rr_ptr, rr_ptr_next;
  logic [BW-1:0]   burst_cnt, burst_next;

  logic [OW-1:0]         scan;
  logic [OW-1:0]         cand;
  logic                  found;
  logic [OW-1:0]         owner_inc;
  logic [DATA_WIDTH-1:0] owner_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      rr_ptr    <= rr_ptr_next;
      burst_cnt <= burst_next;
    end
  end

  always_comb begin
    state_next   = state;
    owner_next   = owner;
    rr_ptr_next  = rr_ptr;
    burst_next   = burst_cnt;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    grant_id     = '0;
    busy         = 1'b0;
    found        = 1'b0;
    cand         = '0;
    scan         = rr_ptr;
    owner_data   = '0;

    // Rotating search: first valid producer at or after rr_ptr wins.
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[scan]) begin
        found = 1'b1;
        cand  = scan;
      end
      scan = (scan == OW'(N_REQ - 1)) ? '0 : scan + 1'b1;
    end

    owner_inc = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    for (int i = 0; i < N_REQ; i++) begin
      if (owner == OW'(i)) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    case (state)
      IDLE: begin
        if (found) begin
          owner_next = cand;
          burst_next = '0;
          state_next = OWN;
        end
      end
      OWN: begin
        busy     = 1'b1;
        grant_id = owner;
        if (!fifo_full) req_ready[owner] = 1'b1;
        // A dropped valid releases the port even while the FIFO is full.
        if (!req_valid[owner]) begin
          state_next  = IDLE;
          rr_ptr_next = owner_inc;
        end else if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = owner_data;
          burst_next   = burst_cnt + 1'b1;
          if (burst_cnt == BW'(MAX_BURST - 1)) begin
            state_next  = IDLE;
            rr_ptr_next = owner_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with N_REQ=4,
// MAX_BURST=4, DATA_WIDTH=16.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic [1:0]  grant_id;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int run_len = 0;

  fifo_wr_arbiter #(
    .N_REQ(4),
    .MAX_BURST(4),
    .DATA_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_id(grant_id),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle protocol properties, sampled on the pre-edge values.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      assert ($onehot0(req_ready)) else begin
        $display("[TB] FAIL assert_onehot req_ready=%b", req_ready);
        bad++;
      end
      assert (!(fifo_wr_en && fifo_full)) else begin
        $display("[TB] FAIL assert_full_write wr_en=%b full=%b", fifo_wr_en, fifo_full);
        bad++;
      end
      if (fifo_wr_en) run_len++;
      else run_len = 0;
      assert (run_len <= 4) else begin
        $display("[TB] FAIL assert_burst run=%0d limit=4", run_len);
        bad++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 64'h4444_3333_2222_1111;
    fifo_full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin $display("[TB] FAIL reset_ready c%0d got=%b want=0000", c, req_ready); bad++; end
      total++; if (fifo_wr_en !== 1'b0) begin $display("[TB] FAIL reset_wr_en c%0d got=%b want=0", c, fifo_wr_en); bad++; end
      total++; if (fifo_wr_data !== 16'h0000) begin $display("[TB] FAIL reset_wr_data c%0d got=%h want=0000", c, fifo_wr_data); bad++; end
      total++; if (grant_id !== 2'd0) begin $display("[TB] FAIL reset_grant c%0d got=%0d want=0", c, grant_id); bad++; end
      total++; if (busy !== 1'b0) begin $display("[TB] FAIL reset_busy c%0d got=%b want=0", c, busy); bad++; end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_single_producer();
    int word;
    logic exp_wr, exp_busy;
    word = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = (word < 6) ? 4'b0001 : 4'b0000;
      req_data  = {48'h0, 16'hA000 + 16'(word)};
      #1;
      exp_wr   = (c >= 1 && c <= 4) || c == 6 || c == 7;
      exp_busy = exp_wr || c == 8;
      total++; if (busy !== exp_busy) begin $display("[TB] FAIL single_busy c%0d got=%b want=%b", c, busy, exp_busy); bad++; end
      total++; if (fifo_wr_en !== exp_wr) begin $display("[TB] FAIL single_wr_en c%0d got=%b want=%b", c, fifo_wr_en, exp_wr); bad++; end
      total++; if (fifo_wr_data !== (exp_wr ? 16'hA000 + 16'(word) : 16'h0)) begin $display("[TB] FAIL single_data c%0d got=%h want=%h", c, fifo_wr_data, exp_wr ? 16'hA000 + 16'(word) : 16'h0); bad++; end
      total++; if (req_ready !== (exp_busy ? 4'b0001 : 4'b0000)) begin $display("[TB] FAIL single_ready c%0d got=%b want=%b", c, req_ready, exp_busy ? 4'b0001 : 4'b0000); bad++; end
      total++; if (grant_id !== 2'd0) begin $display("[TB] FAIL single_grant c%0d got=%0d want=0", c, grant_id); bad++; end
      if (exp_wr) word++;
    end
    req_valid = '0;
  endtask

  task automatic test_all_four();
    logic [15:0] cnt [4];
    logic [15:0] exp_d;
    logic        is_idle;
    int          o;
    for (int i = 0; i < 4; i++) cnt[i] = '0;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'((i + 1) * 4096) + cnt[i];
      #1;
      is_idle = (c % 5 == 0);
      o       = (c / 5) % 4;
      total++; if (busy !== !is_idle) begin $display("[TB] FAIL rr_busy c%0d got=%b want=%b", c, busy, !is_idle); bad++; end
      total++; if (fifo_wr_en !== !is_idle) begin $display("[TB] FAIL rr_wr_en c%0d got=%b want=%b", c, fifo_wr_en, !is_idle); bad++; end
      if (!is_idle) begin
        exp_d = 16'((o + 1) * 4096) + cnt[o];
        total++; if (grant_id !== 2'(o)) begin $display("[TB] FAIL rr_grant c%0d got=%0d want=%0d", c, grant_id, o); bad++; end
        total++; if (fifo_wr_data !== exp_d) begin $display("[TB] FAIL rr_data c%0d got=%h want=%h", c, fifo_wr_data, exp_d); bad++; end
        total++; if (req_ready !== 4'(1 << o)) begin $display("[TB] FAIL rr_ready c%0d got=%b want=%b", c, req_ready, 4'(1 << o)); bad++; end
        cnt[o]++;
      end else begin
        total++; if (req_ready !== 4'b0000) begin $display("[TB] FAIL rr_idle_ready c%0d got=%b want=0000", c, req_ready); bad++; end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_fifo_full();
    int word;
    logic exp_wr, exp_busy;
    word = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      req_data  = {48'h0, 16'hA000 + 16'(word)};
      fifo_full = (c >= 3 && c <= 5);
      #1;
      exp_wr   = (c == 1 || c == 2 || c == 6 || c == 7);
      exp_busy = (c >= 1 && c <= 7);
      total++; if (busy !== exp_busy) begin $display("[TB] FAIL full_busy c%0d got=%b want=%b", c, busy, exp_busy); bad++; end
      total++; if (fifo_wr_en !== exp_wr) begin $display("[TB] FAIL full_wr_en c%0d got=%b want=%b", c, fifo_wr_en, exp_wr); bad++; end
      total++; if (fifo_wr_data !== (exp_wr ? 16'hA000 + 16'(word) : 16'h0)) begin $display("[TB] FAIL full_data c%0d got=%h want=%h", c, fifo_wr_data, exp_wr ? 16'hA000 + 16'(word) : 16'h0); bad++; end
      total++; if (req_ready !== (exp_wr ? 4'b0001 : 4'b0000)) begin $display("[TB] FAIL full_ready c%0d got=%b want=%b", c, req_ready, exp_wr ? 4'b0001 : 4'b0000); bad++; end
      if (exp_wr) word++;
    end
    fifo_full = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_owner_drop();
    logic        e_busy, e_wr;
    logic [1:0]  e_grant;
    logic [15:0] e_data;
    logic [3:0]  e_ready;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid = '0;
      if (c <= 2) req_valid[1] = 1'b1;
      if (c >= 1) req_valid[2] = 1'b1;
      if (c >= 3) req_valid[0] = 1'b1;
      req_data = {16'h0, 16'hC200, (c < 2) ? 16'hB100 : 16'hB101, 16'hA0FF};
      #1;
      case (c)
        1:       begin e_busy = 1; e_wr = 1; e_grant = 2'd1; e_data = 16'hB100; e_ready = 4'b0010; end
        2:       begin e_busy = 1; e_wr = 1; e_grant = 2'd1; e_data = 16'hB101; e_ready = 4'b0010; end
        3:       begin e_busy = 1; e_wr = 0; e_grant = 2'd1; e_data = 16'h0;    e_ready = 4'b0010; end
        5:       begin e_busy = 1; e_wr = 1; e_grant = 2'd2; e_data = 16'hC200; e_ready = 4'b0100; end
        default: begin e_busy = 0; e_wr = 0; e_grant = 2'd0; e_data = 16'h0;    e_ready = 4'b0000; end
      endcase
      total++; if (busy !== e_busy) begin $display("[TB] FAIL drop_busy c%0d got=%b want=%b", c, busy, e_busy); bad++; end
      total++; if (fifo_wr_en !== e_wr) begin $display("[TB] FAIL drop_wr_en c%0d got=%b want=%b", c, fifo_wr_en, e_wr); bad++; end
      total++; if (grant_id !== e_grant) begin $display("[TB] FAIL drop_grant c%0d got=%0d want=%0d", c, grant_id, e_grant); bad++; end
      total++; if (fifo_wr_data !== e_data) begin $display("[TB] FAIL drop_data c%0d got=%h want=%h", c, fifo_wr_data, e_data); bad++; end
      total++; if (req_ready !== e_ready) begin $display("[TB] FAIL drop_ready c%0d got=%b want=%b", c, req_ready, e_ready); bad++; end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = 4'b1000;
      req_data  = {16'hD300 + 16'(c > 0 ? c - 1 : 0), 48'h0};
      #1;
    end
    total++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 16'hD302) begin $display("[TB] FAIL midrst_third_write got=%b/%h want=1/d302", fifo_wr_en, fifo_wr_data); bad++; end
    #2 rst_n = 1'b0;
    #1;
    total++; if (fifo_wr_en !== 1'b0) begin $display("[TB] FAIL midrst_wr_en got=%b want=0", fifo_wr_en); bad++; end
    total++; if (req_ready !== 4'b0000) begin $display("[TB] FAIL midrst_ready got=%b want=0000", req_ready); bad++; end
    total++; if (busy !== 1'b0) begin $display("[TB] FAIL midrst_busy got=%b want=0", busy); bad++; end
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 64'hE003_E002_E001_E000;
    #1;
    total++; if (busy !== 1'b0) begin $display("[TB] FAIL postrst_idle_busy got=%b want=0", busy); bad++; end
    @(negedge clk);
    #1;
    total++; if (grant_id !== 2'd0 || busy !== 1'b1) begin $display("[TB] FAIL postrst_grant got=%0d/%b want=0/1", grant_id, busy); bad++; end
    total++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 16'hE000) begin $display("[TB] FAIL postrst_write got=%b/%h want=1/e000", fifo_wr_en, fifo_wr_data); bad++; end
    total++; if (req_ready !== 4'b0001) begin $display("[TB] FAIL postrst_ready got=%b want=0001", req_ready); bad++; end
    req_valid = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    $display("[TB] starting fifo_wr_arbiter bench");
    test_reset();
    test_single_producer();
    test_all_four();
    test_fifo_full();
    test_owner_drop();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of producers sharing one FIFO write port; SHALL be 2..8.
REQ-002 Parameter MAX_BURST, default 4: maximum writes per grant; SHALL be 1..16.
REQ-003 Parameter DATA_WIDTH, default fifo_pkg::DATA_WIDTH: write data width.
REQ-004 One clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  N_REQ  bit i: producer i has a word to write.
REQ-008 req_data  input  N_REQ*DATA_WIDTH  producer i word at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready  output  N_REQ  bit i: producer i's word is accepted this cycle.
REQ-010 fifo_full  input  1  FIFO full status.
REQ-011 fifo_wr_en  output  1  FIFO write enable.
REQ-012 fifo_wr_data  output  DATA_WIDTH  FIFO write data.
REQ-013 grant_id  output  $clog2(N_REQ)  current owner index.
REQ-014 busy  output  1  high while a producer owns the port.

Function
REQ-015 FSM states SHALL be IDLE and OWN; registered state: owner, rr_ptr, and burst_cnt ($clog2(MAX_BURST+1) bits).
REQ-016 IDLE behaviour:
- req_ready = 0.
- If any req_valid is set, owner <= first set index searching rr_ptr, rr_ptr+1, ... mod N_REQ; burst_cnt <= 0; state <= OWN.
- Arbitration latency is therefore exactly one cycle.
REQ-017 OWN: req_ready SHALL equal one-hot(owner) & ~fifo_full; all other bits SHALL be 0.
REQ-018 A transfer occurs when req_valid[owner] & req_ready[owner]; each transfer increments burst_cnt.
REQ-019 Write port outputs:
- fifo_wr_en = 1 exactly in transfer cycles.
- fifo_wr_data = owner's req_data slice when fifo_wr_en = 1, else 0.
- Both are combinational from registered state and inputs.
REQ-020 OWN -> IDLE on a transfer with burst_cnt == MAX_BURST-1 (burst exhausted).
REQ-021 OWN -> IDLE in a cycle where req_valid[owner] = 0; no transfer occurs in that cycle.
REQ-022 Every OWN -> IDLE exit SHALL set rr_ptr <= (owner+1) mod N_REQ.
REQ-023 fifo_full = 1 in OWN:
- No transfer; burst_cnt, owner and state hold.
- No timeout; ownership is kept until REQ-020 or REQ-021 applies.
REQ-024 Producers SHALL hold req_valid and req_data stable until accepted; no write SHALL ever occur while fifo_full = 1.
REQ-025 grant_id = owner in OWN, 0 in IDLE; busy = 1 exactly in OWN.
REQ-026 A producer's valid asserting mid-burst of another owner SHALL NOT preempt that owner.

Reset
REQ-027 While rst_n = 0:
- state = IDLE, owner = 0, rr_ptr = 0, burst_cnt = 0.
- req_ready = 0, fifo_wr_en = 0, fifo_wr_data = 0, grant_id = 0, busy = 0.
- Takes effect asynchronously, including mid-burst.
REQ-028 The first arbitration after reset release SHALL start its search at index 0.

Verification (bench: N_REQ=4, MAX_BURST=4, DATA_WIDTH=16)
REQ-029 Only req_valid[0] high, 6 words 0xA000..0xA005, full=0. Required response:
- Grant in the cycle after valid seen.
- Writes 0xA000..0xA003 in 4 consecutive cycles, then 1 IDLE cycle.
- Regrant to 0, writes 0xA004..0xA005, then IDLE after valid drops.
REQ-030 All four valid continuously -> grant_id sequence 0,1,2,3,0; 4 writes each; 5-cycle period per owner; each write carries that owner's data.
REQ-031 fifo_full high for 3 cycles after the 2nd write of a burst. Required response:
- fifo_wr_en = 0 and req_ready = 0 for those 3 cycles.
- Writes 3 and 4 follow; burst totals exactly 4.
REQ-032 Owner 1 drops valid after 2 writes while req_valid[2] is high -> IDLE next cycle, rr_ptr = 2, producer 2 granted the following cycle.
REQ-033 rst_n pulled low during the 3rd write of owner 3 -> fifo_wr_en and req_ready fall in the same cycle; after release, with all four valid, the first grant goes to 0.
REQ-034 Every cycle, assertions SHALL check:
- req_ready is one-hot or zero.
- fifo_wr_en implies !fifo_full.
- Never more than MAX_BURST consecutive writes per grant.
